// File: rtl/iec_host_pkg.sv
// Shared types and timing constants for the IEC serial-bus host transmitter.
// All delays are in 1 us ticks.
package iec_host_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StPresence,
        StReady,
        StDelay,
        StEoiWait,
        StEoiAck,
        StBitSetup,
        StBitValid,
        StFrame
    } state_e;

    typedef enum logic [1:0] {
        ErrOk       = 2'd0,
        ErrNoDevice = 2'd1,
        ErrFrame    = 2'd2,
        ErrEoi      = 2'd3
    } err_e;

    localparam int unsigned TickW = 10;

    localparam logic [TickW-1:0] TimeoutTicks    = TickW'(1000);
    localparam logic [TickW-1:0] ReadyDelayTicks = TickW'(40);
    localparam logic [TickW-1:0] BitTicks        = TickW'(20);

    // True on the tick that completes a wait of lim ticks.
    function automatic logic ticks_elapsed(input logic tick, input logic [TickW-1:0] cnt,
                                           input logic [TickW-1:0] lim);
        return tick && (cnt == lim - TickW'(1));
    endfunction

endpackage

// File: rtl/iec_host_usdiv.sv
// Divides the ce pulse stream down to a 1 us tick; clr restarts the phase.
module iec_host_usdiv #(
    parameter int unsigned CE_PER_US = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic ce_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CntW = (CE_PER_US > 1) ? $clog2(CE_PER_US) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CE_PER_US - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    assign tick_o = ce_i && (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (ce_i) begin
            cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/iecdrv_sync.sv
// Two-flop synchronizer for asynchronous bus levels; resets to released (1).
module iecdrv_sync #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/iec_host_tx.sv
// IEC serial-bus host byte transmitter: presence check, ready/EOI handshake,
// LSB-first bit clocking and frame acknowledge, all on open-collector lines.
module iec_host_tx
    import iec_host_pkg::*;
#(
    parameter int unsigned CE_PER_US = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_atn,
    input  logic       tx_eoi,
    input  logic       atn_release,
    output logic       busy,
    output logic       done,
    output logic [1:0] err,
    output logic       iec_atn_o,
    output logic       iec_clk_o,
    output logic       iec_data_o,
    input  logic       iec_clk_i,
    input  logic       iec_data_i
);

    state_e           state_q, state_d;
    logic [TickW-1:0] tcnt_q, tcnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             eoi_q, eoi_d;
    logic             atn_fresh_q, atn_fresh_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    err_e             err_q, err_d;
    logic             atn_o_q, atn_o_d;
    logic             clk_o_q, clk_o_d;
    logic             data_o_q, data_o_d;
    logic [2:0]       own_hist_q, own_hist_d;

    logic [1:0] bus_sync;
    logic       clk_sync, data_sync, data_low;
    logic       tick, tick_eff, accept;
    logic       fin, start_bits;
    err_e       fin_err;

    iecdrv_sync #(.Width(2)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   ({iec_clk_i, iec_data_i}),
        .q_o   (bus_sync)
    );

    assign clk_sync  = bus_sync[1];
    assign data_sync = bus_sync[0];
    // Our own recent low drive is still in the synchronizer; ignore it as a listener signal.
    assign data_low  = !data_sync && (&own_hist_q);
    assign accept    = (state_q == StIdle) && tx_start;

    iec_host_usdiv #(.CE_PER_US(CE_PER_US)) u_usdiv (
        .clk    (clk),
        .reset  (reset),
        .ce_i   (ce),
        .clr_i  (accept),
        .tick_o (tick)
    );

    // Valid time only runs once the bus clock is actually seen released.
    assign tick_eff = tick && ((state_q != StBitValid) || clk_sync);

    always_comb begin
        state_d     = state_q;
        tcnt_d      = tick_eff ? tcnt_q + TickW'(1) : tcnt_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        eoi_d       = eoi_q;
        atn_fresh_d = atn_fresh_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        atn_o_d     = atn_o_q;
        clk_o_d     = clk_o_q;
        data_o_d    = data_o_q;
        own_hist_d  = {own_hist_q[1:0], data_o_q};
        fin         = 1'b0;
        fin_err     = ErrOk;
        start_bits  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tx_start) begin
                    shreg_d  = tx_data;
                    eoi_d    = tx_eoi;
                    busy_d   = 1'b1;
                    clk_o_d  = 1'b0;
                    data_o_d = 1'b1;
                    atn_o_d  = ~tx_atn;
                    if (!tx_atn && !atn_o_q) atn_fresh_d = 1'b1;
                    state_d  = StPresence;
                    tcnt_d   = '0;
                end else if (atn_release) begin
                    if (!atn_o_q) atn_fresh_d = 1'b1;
                    atn_o_d = 1'b1;
                end
            end
            StPresence: begin
                // A fresh ATN release must lead the clock release by BitTicks.
                if (data_low && (!atn_fresh_q || tcnt_q >= BitTicks)) begin
                    atn_fresh_d = 1'b0;
                    clk_o_d     = 1'b1;
                    state_d     = StReady;
                    tcnt_d      = '0;
                end else if (ticks_elapsed(tick_eff, tcnt_q, TimeoutTicks)) begin
                    fin     = 1'b1;
                    fin_err = ErrNoDevice;
                end
            end
            StReady: begin
                if (data_sync) begin
                    state_d = eoi_q ? StEoiWait : StDelay;
                    tcnt_d  = '0;
                end
            end
            StDelay: begin
                if (ticks_elapsed(tick_eff, tcnt_q, ReadyDelayTicks)) start_bits = 1'b1;
            end
            StEoiWait: begin
                if (data_low) begin
                    state_d = StEoiAck;
                    tcnt_d  = '0;
                end else if (ticks_elapsed(tick_eff, tcnt_q, TimeoutTicks)) begin
                    fin     = 1'b1;
                    fin_err = ErrEoi;
                end
            end
            StEoiAck: begin
                if (data_sync) start_bits = 1'b1;
            end
            StBitSetup: begin
                if (ticks_elapsed(tick_eff, tcnt_q, BitTicks)) begin
                    clk_o_d = 1'b1;
                    state_d = StBitValid;
                    tcnt_d  = '0;
                end
            end
            StBitValid: begin
                if (ticks_elapsed(tick_eff, tcnt_q, BitTicks)) begin
                    clk_o_d = 1'b0;
                    tcnt_d  = '0;
                    if (bit_q == 3'd7) begin
                        data_o_d = 1'b1;
                        state_d  = StFrame;
                    end else begin
                        bit_d    = bit_q + 3'd1;
                        shreg_d  = {1'b0, shreg_q[7:1]};
                        data_o_d = shreg_q[1];
                        state_d  = StBitSetup;
                    end
                end
            end
            StFrame: begin
                if (data_low) begin
                    fin     = 1'b1;
                    fin_err = ErrOk;
                end else if (ticks_elapsed(tick_eff, tcnt_q, TimeoutTicks)) begin
                    fin     = 1'b1;
                    fin_err = ErrFrame;
                end
            end
            default: begin
                state_d = StIdle;
                tcnt_d  = '0;
            end
        endcase

        if (start_bits) begin
            clk_o_d  = 1'b0;
            data_o_d = shreg_q[0];
            bit_d    = 3'd0;
            state_d  = StBitSetup;
            tcnt_d   = '0;
        end

        // Success leaves clk held low so the listener keeps the byte framed.
        if (fin) begin
            done_d   = 1'b1;
            err_d    = fin_err;
            busy_d   = 1'b0;
            clk_o_d  = (fin_err != ErrOk);
            data_o_d = 1'b1;
            state_d  = StIdle;
            tcnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            tcnt_q      <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            eoi_q       <= 1'b0;
            atn_fresh_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= ErrOk;
            atn_o_q     <= 1'b1;
            clk_o_q     <= 1'b1;
            data_o_q    <= 1'b1;
            own_hist_q  <= 3'b111;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            eoi_q       <= eoi_d;
            atn_fresh_q <= atn_fresh_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            atn_o_q     <= atn_o_d;
            clk_o_q     <= clk_o_d;
            data_o_q    <= data_o_d;
            own_hist_q  <= own_hist_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign iec_atn_o  = atn_o_q;
    assign iec_clk_o  = clk_o_q;
    assign iec_data_o = data_o_q;

endmodule

// File: tb/tb_iec_host_tx.sv
// Directed bench for iec_host_tx with a scripted listener on the data line.
module tb_iec_host_tx;

    localparam int unsigned CePerUs = 4;   // ce every other clock -> 1 us = 8 clocks

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_atn = 1'b0;
    logic       tx_eoi = 1'b0;
    logic       atn_release = 1'b0;
    logic       busy, done;
    logic [1:0] err;
    logic       iec_atn_o, iec_clk_o, iec_data_o;
    logic       lst_data = 1'b1;
    logic       data_bus;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic        mon_en = 1'b0;
    int unsigned nbits = 0;
    logic [7:0]  cap = 8'h00;

    assign data_bus = iec_data_o & lst_data;

    iec_host_tx #(.CE_PER_US(CePerUs)) dut (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_atn      (tx_atn),
        .tx_eoi      (tx_eoi),
        .atn_release (atn_release),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .iec_atn_o   (iec_atn_o),
        .iec_clk_o   (iec_clk_o),
        .iec_data_o  (iec_data_o),
        .iec_clk_i   (iec_clk_o),
        .iec_data_i  (data_bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ce <= ~ce;

    // Listener samples the data line on every clk release while enabled.
    always @(posedge iec_clk_o or negedge mon_en) begin
        if (!mon_en) begin
            nbits <= 0;
            cap   <= 8'h00;
        end else begin
            cap   <= {data_bus, cap[7:1]};
            nbits <= nbits + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic atn, input logic eoi);
        @(negedge clk);
        tx_data  = d;
        tx_atn   = atn;
        tx_eoi   = eoi;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_clk(input logic lvl, input int unsigned limit, output int unsigned cyc);
        cyc = 0;
        while (iec_clk_o !== lvl && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_done(input int unsigned limit, output int unsigned cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_bits(input int unsigned n, input int unsigned limit);
        int unsigned c = 0;
        while (nbits < n && c < limit) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic set_listener(input logic lvl);
        mon_en   = 1'b0;
        lst_data = lvl;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int unsigned cyc;
        int unsigned pulses;

        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_lines", {iec_atn_o, iec_clk_o, iec_data_o}, 3'b111);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // ATN byte 0x28, listener present and acking the frame
        set_listener(1'b0);
        send(8'h28, 1'b1, 1'b0);
        check_eq("a_busy", busy, 1);
        check_eq("a_atn", iec_atn_o, 0);
        check_eq("a_clk_low", iec_clk_o, 0);
        wait_clk(1'b1, 2000, cyc);
        check_eq("a_clk_rel", iec_clk_o, 1);
        mon_en = 1'b1;
        tx_data = 8'hFF; tx_atn = 1'b0; tx_start = 1'b1; atn_release = 1'b1;
        @(negedge clk);
        tx_start = 1'b0; atn_release = 1'b0;
        check_eq("a_ign_atn", iec_atn_o, 0);
        check_eq("a_ign_busy", busy, 1);
        repeat (40) @(negedge clk);
        lst_data = 1'b1;
        wait_bits(8, 10000);
        check_eq("a_nbits", nbits, 8);
        wait_clk(1'b0, 1000, cyc);
        repeat (80) @(negedge clk);
        lst_data = 1'b0;
        wait_done(2000, cyc);
        check_eq("a_done", done, 1);
        check_eq("a_err", err, 0);
        check_eq("a_byte", cap, 8'h28);
        check_eq("a_clk_held", iec_clk_o, 0);
        check_eq("a_atn_held", iec_atn_o, 0);
        @(negedge clk);
        check_eq("a_pulse", {busy, done}, 2'b00);

        // Byte 0x55 with EOI, ATN released at accept
        set_listener(1'b0);
        send(8'h55, 1'b0, 1'b1);
        check_eq("c_atn_rel", iec_atn_o, 1);
        wait_clk(1'b1, 2000, cyc);
        check_eq("c_atn_gap", (cyc >= 158 && cyc <= 166), 1);
        mon_en = 1'b1;
        repeat (40) @(negedge clk);
        lst_data = 1'b1;
        repeat (2000) @(negedge clk);
        check_eq("c_eoi_wait", {iec_clk_o, nbits[3:0]}, 5'h10);
        lst_data = 1'b0;
        repeat (480) @(negedge clk);
        check_eq("c_eoi_ack", {iec_clk_o, nbits[3:0]}, 5'h10);
        lst_data = 1'b1;
        wait_bits(8, 10000);
        check_eq("c_byte", cap, 8'h55);
        wait_clk(1'b0, 1000, cyc);
        repeat (80) @(negedge clk);
        lst_data = 1'b0;
        wait_done(2000, cyc);
        check_eq("c_done", done, 1);
        check_eq("c_err", err, 0);

        // No listener: presence timeout
        set_listener(1'b1);
        send(8'h00, 1'b1, 1'b0);
        wait_done(9000, cyc);
        check_eq("b_done", done, 1);
        check_eq("b_err", err, 1);
        check_eq("b_time", (cyc >= 7996 && cyc <= 8003), 1);
        check_eq("b_clk_rel", iec_clk_o, 1);
        check_eq("b_atn_held", iec_atn_o, 0);
        @(negedge clk);
        atn_release = 1'b1;
        @(negedge clk);
        atn_release = 1'b0;
        check_eq("b_atn_release", iec_atn_o, 1);

        // Listener omits the frame ack
        set_listener(1'b0);
        send(8'h3A, 1'b0, 1'b0);
        wait_clk(1'b1, 2000, cyc);
        mon_en = 1'b1;
        repeat (40) @(negedge clk);
        lst_data = 1'b1;
        wait_bits(8, 10000);
        check_eq("d_byte", cap, 8'h3A);
        wait_clk(1'b0, 1000, cyc);
        wait_done(9000, cyc);
        check_eq("d_done", done, 1);
        check_eq("d_err", err, 2);
        check_eq("d_time", (cyc >= 7996 && cyc <= 8003), 1);
        check_eq("d_clk_rel", iec_clk_o, 1);

        // EOI requested but listener never acknowledges it
        set_listener(1'b0);
        send(8'h01, 1'b1, 1'b1);
        wait_clk(1'b1, 2000, cyc);
        repeat (40) @(negedge clk);
        lst_data = 1'b1;
        wait_done(9000, cyc);
        check_eq("e_done", done, 1);
        check_eq("e_err", err, 3);
        check_eq("e_clk_rel", iec_clk_o, 1);

        // Reset during bit 3 valid phase
        set_listener(1'b0);
        send(8'h96, 1'b0, 1'b0);
        wait_clk(1'b1, 2000, cyc);
        mon_en = 1'b1;
        repeat (40) @(negedge clk);
        lst_data = 1'b1;
        wait_bits(4, 10000);
        check_eq("f_bits", cap[7:4], 4'h6);
        check_eq("f_valid", iec_clk_o, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("f_busy", busy, 0);
        check_eq("f_lines", {iec_atn_o, iec_clk_o, iec_data_o}, 3'b111);
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            if (done === 1'b1) pulses++;
            @(negedge clk);
        end
        check_eq("f_no_done", pulses, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/iec_host_tx.md
IEC_HOST_TX -- requirements
Module: iec_host_tx

Interface
REQ-001 SHALL have parameter CE_PER_US, default 16, meaning ce pulses per microsecond.
REQ-002 SHALL have port clk input 1, the single clock; all logic on posedge clk.
REQ-003 SHALL have port reset input 1, synchronous active-high reset.
REQ-004 SHALL have port ce input 1, clock enable; all timing counts ce pulses only.
REQ-005 SHALL have port tx_start input 1, one-cycle request to send a byte.
REQ-006 SHALL have port tx_data input 8, byte to send, latched on accepted tx_start.
REQ-007 SHALL have port tx_atn input 1, byte is a command byte (ATN asserted), latched with tx_start.
REQ-008 SHALL have port tx_eoi input 1, signal EOI before this byte, latched with tx_start.
REQ-009 SHALL have port atn_release input 1, one-cycle request to release ATN while idle.
REQ-010 SHALL have port busy output 1, high from accepted start until done.
REQ-011 SHALL have port done output 1, one-cycle pulse at end of transfer.
REQ-012 SHALL have port err output 2, status valid with done: 0 ok, 1 no device, 2 frame timeout, 3 EOI timeout.
REQ-013 SHALL have ports iec_atn_o, iec_clk_o, iec_data_o output 1 each, open-collector drives, 1 = released.
REQ-014 SHALL have ports iec_clk_i, iec_data_i input 1 each, wired-AND bus levels, asynchronous.

Function
REQ-015 SHALL pass iec_clk_i/iec_data_i through two-flop synchronizers before use.
REQ-016 SHALL derive a 1 us tick from ce via a modulo-CE_PER_US counter; all delays below count ticks.
REQ-017 SHALL accept tx_start only in IDLE; tx_start while busy is ignored with no side effect.
REQ-018 SHALL on accept: latch inputs, busy=1, iec_clk_o=0, iec_data_o=1, iec_atn_o=~tx_atn, enter PRESENCE.
REQ-019 PRESENCE SHALL wait for data low; if none within 1000 ticks, finish with err=1.
REQ-020 SHALL then release clk (iec_clk_o=1), enter READY; READY waits unbounded for data high (listener ready).
REQ-021 With EOI latched, SHALL enter EOI_WAIT: await data low within 1000 ticks (else err=3), then EOI_ACK awaits data high unbounded.
REQ-022 Without EOI, SHALL wait 40 ticks after READY; SHALL then drive clk low and enter bit loop.
REQ-023 Each bit, LSB first: BIT_SETUP drives iec_data_o=bit for 20 ticks with clk low; BIT_VALID releases clk 20 ticks; then clk low, data released.
REQ-024 After bit 7 SHALL enter FRAME: clk held low, data released; data low within 1000 ticks -> err=0, else err=2.
REQ-025 On finish SHALL pulse done with err for one cycle, busy=0, return IDLE; clk stays low on success, released on error.
REQ-026 iec_atn_o SHALL stay at the latched ATN value after done; atn_release in IDLE sets iec_atn_o=1 next cycle; ignored while busy.
REQ-027 tx_start with tx_atn=0 SHALL release ATN at accept; a release of ATN shall precede clk release by at least 20 ticks.
REQ-028 Timeout boundary: data low observed on tick 1000 counts as success; tick counter resets on every state change.
REQ-029 ce low SHALL freeze all timing; synchronizers and edge sampling continue.

Reset
REQ-030 Reset SHALL set state IDLE, busy=0, done=0, err=0, all iec_*_o=1, counters 0, at next clk edge.
REQ-031 Reset mid-transfer SHALL abort immediately with no done pulse and all lines released.

Structure
REQ-032 State enum, err codes and tick constants (1000, 40, 20) SHALL live in shared package iec_host_pkg.
REQ-033 Synchronizers SHALL reuse existing iecdrv_sync; one sub-module iec_host_usdiv (ce-to-us tick counter) is natural.

Verification
REQ-034 ATN byte 0x28, responder drive model present -> bits LSB-first on data, done, err=0, iec_atn_o stays 0.
REQ-035 No listener (data never low) -> done at 1000 us (+sync latency), err=1, clk released.
REQ-036 Byte 0x55 with tx_eoi, listener acks 60 us low -> EOI handshake then bits, err=0.
REQ-037 Listener omits frame ack after 8 bits -> err=2 at 1000 us after bit 7.
REQ-038 Reset asserted during BIT_VALID of bit 3 -> next cycle all outputs 1, busy=0, no done; tx_start during busy ignored.
